// File: rtl/ell201_pkg.sv
// Shared types and helpers for the mental-math answer entry block.
// Holds the entry FSM state encoding, BCD/answer widths and the
// BCD-pair to binary conversion used when the units digit commits.
package ell201_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TENS  = 2'd1,
    UNITS = 2'd2,
    DONE  = 2'd3
  } entry_state_t;

  localparam int unsigned BCD_MAX  = 9;
  localparam int unsigned ANSWER_W = 7;
  localparam int unsigned DIGIT_W  = 4;

  // True when the switch value is a legal decimal digit.
  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return (d <= DIGIT_W'(BCD_MAX));
  endfunction

  // tens*10 + units, with the multiply built from two shifts.
  // Both digits are <= 9, so the sum never exceeds 99 and fits ANSWER_W.
  function automatic logic [ANSWER_W-1:0] bcd_to_bin(
    input logic [DIGIT_W-1:0] tens,
    input logic [DIGIT_W-1:0] units
  );
    logic [ANSWER_W-1:0] t_ext;
    logic [ANSWER_W-1:0] u_ext;
    t_ext = {{(ANSWER_W-DIGIT_W){1'b0}}, tens};
    u_ext = {{(ANSWER_W-DIGIT_W){1'b0}}, units};
    return (t_ext << 3) + (t_ext << 1) + u_ext;
  endfunction

endpackage

// File: rtl/bcd_answer_entry_if.sv
// Board-side bundle for the answer entry block: raw buttons, digit
// switches and arm level in, accepted digits / answer / status out.
// slave is the entry block's view, master is the driver's view.
interface bcd_answer_entry_if;
  import ell201_pkg::*;

  logic                arm;
  logic                enter_btn;
  logic                clear_btn;
  logic [DIGIT_W-1:0]  digit_sw;
  logic [DIGIT_W-1:0]  entry_tens;
  logic [DIGIT_W-1:0]  entry_units;
  logic [ANSWER_W-1:0] answer;
  logic                answer_valid;
  logic                digit_err;
  logic                entry_timeout;

  modport slave (
    input  arm, enter_btn, clear_btn, digit_sw,
    output entry_tens, entry_units, answer, answer_valid, digit_err, entry_timeout
  );

  modport master (
    output arm, enter_btn, clear_btn, digit_sw,
    input  entry_tens, entry_units, answer, answer_valid, digit_err, entry_timeout
  );

endinterface

// File: rtl/bcd_answer_entry_btn_debounce.sv
// btn_debounce: two-flop synchronizer, stable-sample counter and
// rising-edge strobe for one raw push-button.
// A new level is accepted after DEBOUNCE_CYCLES consecutive synchronized
// samples that differ from the current level; the strobe is registered
// one cycle after the accepted level rises, so a press strobe is high in
// the cycle after edge k+2+DEBOUNCE_CYCLES when the raw input is first
// sampled high at edge k.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       level_q, level_d;
  logic       level_prev_q, level_prev_d;
  logic       strobe_q, strobe_d;
  logic [3:0] cnt_q, cnt_d;

  // Next-state: synchronize, count stable disagreeing samples, detect rise.
  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    level_d      = level_q;
    cnt_d        = cnt_q;
    level_prev_d = level_q;
    strobe_d     = level_q & ~level_prev_q;
    if (sync2_q == level_q) begin
      cnt_d = 4'd0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = 4'd0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Debouncer state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      strobe_q     <= 1'b0;
      cnt_q        <= 4'd0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      strobe_q     <= strobe_d;
      cnt_q        <= cnt_d;
    end
  end

  assign press = strobe_q;

endmodule

// File: rtl/bcd_answer_entry.sv
// bcd_answer_entry: collects a two-digit BCD answer (tens then units)
// from the digit switches and ENTER/CLEAR buttons, and presents it as a
// 7-bit binary value for the game controller's compare.
// Optional feature macro: ENTRY_TIMEOUT_EN -- when defined, a partial
// entry left idle for TIMEOUT_CYCLES cycles is discarded and entry
// restarts at the tens digit with a one-cycle entry_timeout pulse.
module bcd_answer_entry
  import ell201_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_answer_entry_if.slave   bus
);

  logic enter_press;
  logic clear_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (bus.enter_btn),
    .press   (enter_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (bus.clear_btn),
    .press   (clear_press)
  );

  entry_state_t        state_q, state_d;
  logic [DIGIT_W-1:0]  tens_q, tens_d;
  logic [DIGIT_W-1:0]  units_q, units_d;
  logic [ANSWER_W-1:0] answer_q, answer_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                tmo_q, tmo_d;

`ifdef ENTRY_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

  // Entry FSM: arm drop beats CLEAR, CLEAR beats ENTER, DONE is frozen.
  always_comb begin
    state_d  = state_q;
    tens_d   = tens_q;
    units_d  = units_q;
    answer_d = answer_q;
    err_d    = err_q;
    valid_d  = 1'b0;
    tmo_d    = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
    idle_cnt_d = '0;
`endif
    case (state_q)
      IDLE: begin
        tens_d   = '0;
        units_d  = '0;
        answer_d = '0;
        err_d    = 1'b0;
        if (bus.arm) begin
          state_d = TENS;
        end else begin
          state_d = IDLE;
        end
      end
      TENS, UNITS: begin
        if (!bus.arm) begin
          state_d  = IDLE;
          tens_d   = '0;
          units_d  = '0;
          answer_d = '0;
          err_d    = 1'b0;
        end else if (clear_press) begin
          state_d = TENS;
          tens_d  = '0;
          units_d = '0;
          err_d   = 1'b0;
        end else if (enter_press) begin
          if (is_bcd(bus.digit_sw)) begin
            err_d = 1'b0;
            if (state_q == TENS) begin
              tens_d  = bus.digit_sw;
              state_d = UNITS;
            end else begin
              units_d  = bus.digit_sw;
              answer_d = bcd_to_bin(tens_q, bus.digit_sw);
              valid_d  = 1'b1;
              state_d  = DONE;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
`ifdef ENTRY_TIMEOUT_EN
          if ((idle_cnt_q + 1'b1) == IDLE_LIMIT) begin
            tens_d     = '0;
            units_d    = '0;
            state_d    = TENS;
            tmo_d      = 1'b1;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
`else
          state_d = state_q;
`endif
        end
      end
      DONE: begin
        if (!bus.arm) begin
          state_d  = IDLE;
          tens_d   = '0;
          units_d  = '0;
          answer_d = '0;
          err_d    = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d  = IDLE;
        tens_d   = '0;
        units_d  = '0;
        answer_d = '0;
        err_d    = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tens_q   <= '0;
      units_q  <= '0;
      answer_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tens_q   <= tens_d;
      units_q  <= units_d;
      answer_q <= answer_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  // Idle counter register for abandoned partial entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`endif

  assign bus.entry_tens    = tens_q;
  assign bus.entry_units   = units_q;
  assign bus.answer        = answer_q;
  assign bus.answer_valid  = valid_q;
  assign bus.digit_err     = err_q;
  assign bus.entry_timeout = tmo_q;

endmodule

// File: tb/tb_bcd_answer_entry.sv
// Directed self-checking bench for bcd_answer_entry (DEBOUNCE_CYCLES=4,
// TIMEOUT_CYCLES=16). Outputs are sampled on the falling clock edge.
module tb_bcd_answer_entry;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   vcnt;
  int   tcnt;

  bcd_answer_entry_if bus ();

  bcd_answer_entry #(
    .DEBOUNCE_CYCLES (4),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles in which answer_valid / entry_timeout were high.
  always @(posedge clk) begin
    if (bus.answer_valid === 1'b1) vcnt <= vcnt + 1;
    if (bus.entry_timeout === 1'b1) tcnt <= tcnt + 1;
  end

  task automatic press(input logic en, input logic cl, input logic [3:0] d, input int hold);
    @(negedge clk);
    bus.digit_sw  = d;
    bus.enter_btn = en;
    bus.clear_btn = cl;
    repeat (hold) @(negedge clk);
    bus.enter_btn = 1'b0;
    bus.clear_btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic rearm();
    @(negedge clk);
    bus.arm = 1'b0;
    repeat (2) @(negedge clk);
    bus.arm = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (bus.entry_tens !== 4'd0) begin bad++; $display("FAIL reset_tens got=%0d exp=0", bus.entry_tens); end
    total++; if (bus.entry_units !== 4'd0) begin bad++; $display("FAIL reset_units got=%0d exp=0", bus.entry_units); end
    total++; if (bus.answer !== 7'd0) begin bad++; $display("FAIL reset_answer got=%0d exp=0", bus.answer); end
    total++; if (bus.answer_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.answer_valid); end
    total++; if (bus.digit_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.digit_err); end
    total++; if (bus.entry_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", bus.entry_timeout); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int v0;
    rearm();
    v0 = vcnt;
    press(1'b1, 1'b0, 4'd4, 6);
    total++; if (bus.entry_tens !== 4'd4) begin bad++; $display("FAIL basic_tens got=%0d exp=4", bus.entry_tens); end
    total++; if (bus.entry_units !== 4'd0) begin bad++; $display("FAIL basic_units0 got=%0d exp=0", bus.entry_units); end
    press(1'b1, 1'b0, 4'd2, 6);
    total++; if (bus.entry_units !== 4'd2) begin bad++; $display("FAIL basic_units got=%0d exp=2", bus.entry_units); end
    total++; if (bus.answer !== 7'd42) begin bad++; $display("FAIL basic_answer got=%0d exp=42", bus.answer); end
    total++; if (vcnt - v0 !== 1) begin bad++; $display("FAIL basic_valid_cycles got=%0d exp=1", vcnt - v0); end
    press(1'b1, 1'b0, 4'd7, 6);
    total++; if (bus.entry_units !== 4'd2) begin bad++; $display("FAIL done_ignores_enter got=%0d exp=2", bus.entry_units); end
    press(1'b0, 1'b1, 4'd0, 6);
    total++; if (bus.answer !== 7'd42) begin bad++; $display("FAIL done_ignores_clear got=%0d exp=42", bus.answer); end
    total++; if (vcnt - v0 !== 1) begin bad++; $display("FAIL done_no_revalid got=%0d exp=1", vcnt - v0); end
  endtask

  task automatic test_latency();
    rearm();
    @(negedge clk);
    bus.digit_sw  = 4'd8;
    bus.enter_btn = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    total++; if (bus.entry_tens !== 4'd0) begin bad++; $display("FAIL latency_early got=%0d exp=0", bus.entry_tens); end
    @(posedge clk);
    #1;
    total++; if (bus.entry_tens !== 4'd8) begin bad++; $display("FAIL latency_edge7 got=%0d exp=8", bus.entry_tens); end
    @(negedge clk);
    bus.enter_btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_digit_err();
    int v0;
    rearm();
    v0 = vcnt;
    press(1'b1, 1'b0, 4'd12, 6);
    total++; if (bus.digit_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", bus.digit_err); end
    total++; if (bus.entry_tens !== 4'd0) begin bad++; $display("FAIL err_tens_kept got=%0d exp=0", bus.entry_tens); end
    press(1'b1, 1'b0, 4'd9, 6);
    total++; if (bus.digit_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", bus.digit_err); end
    total++; if (bus.entry_tens !== 4'd9) begin bad++; $display("FAIL err_tens9 got=%0d exp=9", bus.entry_tens); end
    press(1'b1, 1'b0, 4'd3, 6);
    total++; if (bus.answer !== 7'd93) begin bad++; $display("FAIL err_answer93 got=%0d exp=93", bus.answer); end
    total++; if (vcnt - v0 !== 1) begin bad++; $display("FAIL err_valid_cycles got=%0d exp=1", vcnt - v0); end
  endtask

  task automatic test_debounce();
    int v0;
    rearm();
    v0 = vcnt;
    press(1'b1, 1'b0, 4'd5, 3);
    total++; if (bus.entry_tens !== 4'd0) begin bad++; $display("FAIL short_pulse_tens got=%0d exp=0", bus.entry_tens); end
    press(1'b1, 1'b0, 4'd6, 20);
    total++; if (bus.entry_tens !== 4'd6) begin bad++; $display("FAIL long_hold_tens got=%0d exp=6", bus.entry_tens); end
    total++; if (bus.entry_units !== 4'd0) begin bad++; $display("FAIL long_hold_single got=%0d exp=0", bus.entry_units); end
    total++; if (vcnt - v0 !== 0) begin bad++; $display("FAIL long_hold_novalid got=%0d exp=0", vcnt - v0); end
  endtask

  task automatic test_clear_wins();
    int v0;
    rearm();
    v0 = vcnt;
    press(1'b1, 1'b0, 4'd7, 6);
    total++; if (bus.entry_tens !== 4'd7) begin bad++; $display("FAIL cw_tens7 got=%0d exp=7", bus.entry_tens); end
    press(1'b1, 1'b1, 4'd3, 6);
    total++; if (bus.entry_tens !== 4'd0) begin bad++; $display("FAIL cw_tens_cleared got=%0d exp=0", bus.entry_tens); end
    total++; if (bus.entry_units !== 4'd0) begin bad++; $display("FAIL cw_units got=%0d exp=0", bus.entry_units); end
    total++; if (vcnt - v0 !== 0) begin bad++; $display("FAIL cw_novalid got=%0d exp=0", vcnt - v0); end
    press(1'b1, 1'b0, 4'd1, 6);
    total++; if (bus.entry_tens !== 4'd1) begin bad++; $display("FAIL cw_back_in_tens got=%0d exp=1", bus.entry_tens); end
  endtask

  task automatic test_arm_drop();
    rearm();
    press(1'b1, 1'b0, 4'd5, 6);
    total++; if (bus.entry_tens !== 4'd5) begin bad++; $display("FAIL ad_tens5 got=%0d exp=5", bus.entry_tens); end
    @(negedge clk);
    bus.arm = 1'b0;
    @(posedge clk);
    #1;
    total++; if (bus.entry_tens !== 4'd0) begin bad++; $display("FAIL ad_tens_zero got=%0d exp=0", bus.entry_tens); end
    total++; if (bus.answer !== 7'd0) begin bad++; $display("FAIL ad_answer_zero got=%0d exp=0", bus.answer); end
  endtask

  task automatic test_rst_mid_debounce();
    rearm();
    press(1'b1, 1'b0, 4'd5, 6);
    @(negedge clk);
    bus.digit_sw  = 4'd6;
    bus.enter_btn = 1'b1;
    repeat (4) @(negedge clk);
    rst_n         = 1'b0;
    bus.enter_btn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (bus.entry_tens !== 4'd0) begin bad++; $display("FAIL rst_tens_zero got=%0d exp=0", bus.entry_tens); end
    repeat (12) @(negedge clk);
    total++; if (bus.entry_tens !== 4'd0) begin bad++; $display("FAIL rst_no_stale_press got=%0d exp=0", bus.entry_tens); end
    press(1'b1, 1'b0, 4'd6, 2);
    total++; if (bus.entry_tens !== 4'd0) begin bad++; $display("FAIL rst_short_ignored got=%0d exp=0", bus.entry_tens); end
    press(1'b1, 1'b0, 4'd3, 6);
    total++; if (bus.entry_tens !== 4'd3) begin bad++; $display("FAIL rst_then_press got=%0d exp=3", bus.entry_tens); end
  endtask

  task automatic test_timeout();
    int t0;
    rearm();
    t0 = tcnt;
    press(1'b1, 1'b0, 4'd3, 6);
    total++; if (bus.entry_tens !== 4'd3) begin bad++; $display("FAIL to_tens3 got=%0d exp=3", bus.entry_tens); end
`ifdef ENTRY_TIMEOUT_EN
    repeat (10) @(negedge clk);
    total++; if (tcnt - t0 !== 1) begin bad++; $display("FAIL to_pulse_cycles got=%0d exp=1", tcnt - t0); end
    total++; if (bus.entry_tens !== 4'd0) begin bad++; $display("FAIL to_tens_cleared got=%0d exp=0", bus.entry_tens); end
    press(1'b1, 1'b0, 4'd4, 6);
    total++; if (bus.entry_tens !== 4'd4) begin bad++; $display("FAIL to_back_in_tens got=%0d exp=4", bus.entry_tens); end
`else
    repeat (60) @(negedge clk);
    total++; if (tcnt - t0 !== 0) begin bad++; $display("FAIL to_no_pulse got=%0d exp=0", tcnt - t0); end
    total++; if (bus.entry_tens !== 4'd3) begin bad++; $display("FAIL to_partial_held got=%0d exp=3", bus.entry_tens); end
`endif
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.arm       = 1'b0;
    bus.enter_btn = 1'b0;
    bus.clear_btn = 1'b0;
    bus.digit_sw  = 4'd0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_latency();
    test_digit_err();
    test_debounce();
    test_clear_wins();
    test_arm_drop();
    test_rst_mid_debounce();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    vcnt = 0;
    tcnt = 0;
  end

endmodule
